// File: rtl/move_sequencer.sv
// move_sequencer: multi-cycle move engine for the 4x4 tile game.
// A single lane-merge datapath is time-multiplexed over the four lanes
// (rows or columns), one lane per cycle, followed by a one-cycle DONE
// pulse that presents the new board, changed flag, score and win flag.
// Optional feature: define MOVE_SEQ_DEFEAT_EN to add a CHECK state and
// the no_moves output (board full with no adjacent equal pair).
module move_sequencer #(
   parameter int WIN_EXP = 11,
   parameter int SCORE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         dir,
   input  logic [63:0]        grid_in,
   output logic               busy,
   output logic               done,
   output logic [63:0]        grid_out,
   output logic               changed,
   output logic               win,
   output logic [SCORE_W-1:0] score_add
`ifdef MOVE_SEQ_DEFEAT_EN
   ,
   output logic               no_moves
`endif
);

   // Wide enough for score_add plus the largest per-lane score (two 2^15 merges).
   localparam int SUM_W = ((SCORE_W > 17) ? SCORE_W : 17) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROC  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [15:0] lane;
      logic [16:0] score;
      logic        win;
   } merge_t;

   state_t               state_r, state_n;
   logic [1:0]           lane_r, lane_n;
   logic [1:0]           dir_r, dir_n;
   logic [63:0]          work_r, work_n;
   logic [63:0]          orig_r, orig_n;
   logic [SCORE_W-1:0]   score_r, score_n;
   logic                 win_r, win_n;
   logic [15:0]          lane_in_s;
   merge_t               merged_s;

   // Bit offset of element k of lane 'lane' for direction d (element 0 = destination side).
   function automatic logic [5:0] cell_index(input logic [1:0] d, input logic [1:0] lane,
                                             input logic [1:0] k);
      logic [1:0] r;
      logic [1:0] c;
      case (d)
         2'd0:    begin r = lane;        c = 2'd3 - k; end
         2'd1:    begin r = lane;        c = k;        end
         2'd2:    begin r = k;           c = lane;     end
         default: begin r = 2'd3 - k;    c = lane;     end
      endcase
      return {r, c, 2'b00};
   endfunction

   // Compact, merge equal neighbours once (destination side first), re-compact.
   function automatic merge_t merge_lane(input logic [15:0] lane_in);
      logic [3:0] comp [5];
      logic [3:0] outv [4];
      logic [2:0] n;
      logic       skip;
      merge_t     res;
      res = '0;
      for (int k = 0; k < 5; k++) comp[k] = 4'd0;
      for (int k = 0; k < 4; k++) outv[k] = 4'd0;
      n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (lane_in[k*4 +: 4] != 4'd0) begin
            comp[n] = lane_in[k*4 +: 4];
            n = n + 3'd1;
         end else begin
            n = n;
         end
      end
      n    = 3'd0;
      skip = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[k] != 4'd0) begin
            // Exponent 15 never merges so the 4-bit cell cannot overflow.
            if ((comp[k] == comp[k+1]) && (comp[k] != 4'hF)) begin
               outv[n[1:0]] = comp[k] + 4'd1;
               res.score    = res.score + (17'd1 << (comp[k] + 4'd1));
               if ((int'(comp[k]) + 1) >= WIN_EXP) res.win = 1'b1;
               else res.win = res.win;
               skip = 1'b1;
            end else begin
               outv[n[1:0]] = comp[k];
            end
            n = n + 3'd1;
         end else begin
            skip = 1'b0;
         end
      end
      for (int k = 0; k < 4; k++) res.lane[k*4 +: 4] = outv[k];
      return res;
   endfunction

   // Saturating accumulate of a lane score into the running score.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [16:0] b);
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] max_v;
      sum   = SUM_W'(a) + SUM_W'(b);
      max_v = SUM_W'({SCORE_W{1'b1}});
      if (sum > max_v) return {SCORE_W{1'b1}};
      else return sum[SCORE_W-1:0];
   endfunction

`ifdef MOVE_SEQ_DEFEAT_EN
   // True when the board is full and no horizontal or vertical neighbours match.
   function automatic logic board_stuck(input logic [63:0] g);
      logic stuck;
      stuck = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (g[i*4 +: 4] == 4'd0) stuck = 1'b0;
         else stuck = stuck;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (g[(r*4+c)*4 +: 4] == g[(r*4+c+1)*4 +: 4]) stuck = 1'b0;
            else stuck = stuck;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (g[(r*4+c)*4 +: 4] == g[((r+1)*4+c)*4 +: 4]) stuck = 1'b0;
            else stuck = stuck;
         end
      end
      return stuck;
   endfunction
`endif

   // Next-state logic and the shared lane-merge datapath.
   always_comb begin
      state_n   = state_r;
      lane_n    = lane_r;
      dir_n     = dir_r;
      work_n    = work_r;
      orig_n    = orig_r;
      score_n   = score_r;
      win_n     = win_r;
      lane_in_s = 16'd0;
      merged_s  = '0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_n = S_PROC;
               lane_n  = 2'd0;
               dir_n   = dir;
               work_n  = grid_in;
               orig_n  = grid_in;
               score_n = '0;
               win_n   = 1'b0;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_PROC: begin
            for (int k = 0; k < 4; k++)
               lane_in_s[k*4 +: 4] = work_r[cell_index(dir_r, lane_r, 2'(k)) +: 4];
            merged_s = merge_lane(lane_in_s);
            for (int k = 0; k < 4; k++)
               work_n[cell_index(dir_r, lane_r, 2'(k)) +: 4] = merged_s.lane[k*4 +: 4];
            score_n = sat_add(score_r, merged_s.score);
            win_n   = win_r | merged_s.win;
            lane_n  = lane_r + 2'd1;
            if (lane_r == 2'd3) begin
`ifdef MOVE_SEQ_DEFEAT_EN
               state_n = S_CHECK;
`else
               state_n = S_DONE;
`endif
            end else begin
               state_n = S_PROC;
            end
         end
         S_CHECK: state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State and working registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
         lane_r  <= 2'd0;
         dir_r   <= 2'd0;
         work_r  <= 64'd0;
         orig_r  <= 64'd0;
         score_r <= '0;
         win_r   <= 1'b0;
      end else begin
         state_r <= state_n;
         lane_r  <= lane_n;
         dir_r   <= dir_n;
         work_r  <= work_n;
         orig_r  <= orig_n;
         score_r <= score_n;
         win_r   <= win_n;
      end
   end

   // Registered outputs; results load on entry to DONE and hold until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         grid_out  <= 64'd0;
         changed   <= 1'b0;
         win       <= 1'b0;
         score_add <= '0;
`ifdef MOVE_SEQ_DEFEAT_EN
         no_moves  <= 1'b0;
`endif
      end else begin
         busy <= (state_n != S_IDLE);
         done <= (state_n == S_DONE);
         if (state_n == S_DONE) begin
            grid_out  <= work_n;
            changed   <= (work_n != orig_r);
            win       <= win_n;
            score_add <= score_n;
`ifdef MOVE_SEQ_DEFEAT_EN
            no_moves  <= board_stuck(work_n);
`endif
         end
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed self-checking bench for move_sequencer (default and SCORE_W=8 instances).
module tb_move_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  dir;
   logic [63:0] grid_in;
   logic        busy, done, changed, win;
   logic [63:0] grid_out;
   logic [15:0] score_add;
   logic        busy8, done8, changed8, win8;
   logic [63:0] grid_out8;
   logic [7:0]  score_add8;
`ifdef MOVE_SEQ_DEFEAT_EN
   logic        no_moves, no_moves8;
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   move_sequencer #(.WIN_EXP(11), .SCORE_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .dir(dir), .grid_in(grid_in),
      .busy(busy), .done(done), .grid_out(grid_out), .changed(changed),
      .win(win), .score_add(score_add)
`ifdef MOVE_SEQ_DEFEAT_EN
      , .no_moves(no_moves)
`endif
   );

   move_sequencer #(.WIN_EXP(11), .SCORE_W(8)) dut8 (
      .clk(clk), .reset(reset), .start(start), .dir(dir), .grid_in(grid_in),
      .busy(busy8), .done(done8), .grid_out(grid_out8), .changed(changed8),
      .win(win8), .score_add(score_add8)
`ifdef MOVE_SEQ_DEFEAT_EN
      , .no_moves(no_moves8)
`endif
   );

   function automatic logic [63:0] setrow(input logic [63:0] g, input int r,
                                          input logic [3:0] a0, input logic [3:0] a1,
                                          input logic [3:0] a2, input logic [3:0] a3);
      logic [63:0] t;
      t = g;
      t[(r*4+0)*4 +: 4] = a0;
      t[(r*4+1)*4 +: 4] = a1;
      t[(r*4+2)*4 +: 4] = a2;
      t[(r*4+3)*4 +: 4] = a3;
      return t;
   endfunction

   function automatic logic [63:0] setcol(input logic [63:0] g, input int c,
                                          input logic [3:0] a0, input logic [3:0] a1,
                                          input logic [3:0] a2, input logic [3:0] a3);
      logic [63:0] t;
      t = g;
      t[(0*4+c)*4 +: 4] = a0;
      t[(1*4+c)*4 +: 4] = a1;
      t[(2*4+c)*4 +: 4] = a2;
      t[(3*4+c)*4 +: 4] = a3;
      return t;
   endfunction

   // Issue one move; start stays high through edge 'hold' after the start edge.
   // Bounded to 12 edges: lat stays -1 if done never appears.
   task automatic run_move(input logic [1:0] d, input logic [63:0] g, input int hold,
                           output int lat, output int pulses, output logic busy0);
      lat = -1; pulses = 0;
      @(negedge clk);
      dir = d; grid_in = g; start = 1'b1;
      @(posedge clk); #1;
      busy0 = busy;
      if (hold == 0) start = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (lat < 0) lat = i;
         end
         if (i >= hold) start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; dir = 2'd0; grid_in = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
      total++; if (grid_out !== 64'd0) $display("FAIL reset_grid: got %h expected 0", grid_out); else passed++;
      total++; if (changed !== 1'b0) $display("FAIL reset_changed: got %b expected 0", changed); else passed++;
      total++; if (win !== 1'b0) $display("FAIL reset_win: got %b expected 0", win); else passed++;
      total++; if (score_add !== 16'd0) $display("FAIL reset_score: got %0d expected 0", score_add); else passed++;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_left_merge();
      int lat, pulses; logic b0; logic [63:0] g, e;
      g = setrow(64'd0, 0, 4'd1, 4'd1, 4'd2, 4'd2);
      e = setrow(64'd0, 0, 4'd2, 4'd3, 4'd0, 4'd0);
      run_move(2'd1, g, 0, lat, pulses, b0);
      total++; if (b0 !== 1'b1) $display("FAIL left_busy: got %b expected 1", b0); else passed++;
      total++; if (grid_out !== e) $display("FAIL left_grid: got %h expected %h", grid_out, e); else passed++;
      total++; if (changed !== 1'b1) $display("FAIL left_changed: got %b expected 1", changed); else passed++;
      total++; if (score_add !== 16'd12) $display("FAIL left_score: got %0d expected 12", score_add); else passed++;
      total++; if (win !== 1'b0) $display("FAIL left_win: got %b expected 0", win); else passed++;
      total++; if (lat != LAT) $display("FAIL left_latency: got %0d expected %0d", lat, LAT); else passed++;
      total++; if (pulses != 1) $display("FAIL left_pulses: got %0d expected 1", pulses); else passed++;
   endtask

   task automatic test_right_triple();
      int lat, pulses; logic b0; logic [63:0] g, e;
      g = setrow(64'd0, 1, 4'd1, 4'd1, 4'd1, 4'd0);
      e = setrow(64'd0, 1, 4'd0, 4'd0, 4'd1, 4'd2);
      run_move(2'd0, g, 0, lat, pulses, b0);
      total++; if (grid_out !== e) $display("FAIL right_grid: got %h expected %h", grid_out, e); else passed++;
      total++; if (score_add !== 16'd4) $display("FAIL right_score: got %0d expected 4", score_add); else passed++;
      total++; if (changed !== 1'b1) $display("FAIL right_changed: got %b expected 1", changed); else passed++;
      total++; if (pulses != 1) $display("FAIL right_pulses: got %0d expected 1", pulses); else passed++;
   endtask

   task automatic test_up_down();
      int lat, pulses; logic b0; logic [63:0] g, e;
      g = setcol(64'd0, 2, 4'd3, 4'd0, 4'd3, 4'd1);
      e = setcol(64'd0, 2, 4'd0, 4'd0, 4'd4, 4'd1);
      run_move(2'd3, g, 0, lat, pulses, b0);
      total++; if (grid_out !== e) $display("FAIL down_grid: got %h expected %h", grid_out, e); else passed++;
      total++; if (score_add !== 16'd16) $display("FAIL down_score: got %0d expected 16", score_add); else passed++;
      g = setcol(64'd0, 3, 4'd2, 4'd2, 4'd2, 4'd2);
      e = setcol(64'd0, 3, 4'd3, 4'd3, 4'd0, 4'd0);
      run_move(2'd2, g, 0, lat, pulses, b0);
      total++; if (grid_out !== e) $display("FAIL up_grid: got %h expected %h", grid_out, e); else passed++;
      total++; if (score_add !== 16'd16) $display("FAIL up_score: got %0d expected 16", score_add); else passed++;
   endtask

   task automatic test_noop_and_ignored_start();
      int lat, pulses; logic b0; logic [63:0] g;
      g = setcol(64'd0, 0, 4'd1, 4'd2, 4'd3, 4'd4);
      g = setcol(g, 1, 4'd5, 4'd6, 4'd0, 4'd0);
      run_move(2'd2, g, 5, lat, pulses, b0);
      total++; if (grid_out !== g) $display("FAIL noop_grid: got %h expected %h", grid_out, g); else passed++;
      total++; if (changed !== 1'b0) $display("FAIL noop_changed: got %b expected 0", changed); else passed++;
      total++; if (score_add !== 16'd0) $display("FAIL noop_score: got %0d expected 0", score_add); else passed++;
      total++; if (pulses != 1) $display("FAIL noop_pulses: got %0d expected 1", pulses); else passed++;
   endtask

   task automatic test_win_saturation();
      int lat, pulses; logic b0; logic [63:0] g, e;
      g = setrow(64'd0, 0, 4'd10, 4'd10, 4'd0, 4'd0);
      e = setrow(64'd0, 0, 4'd11, 4'd0, 4'd0, 4'd0);
      run_move(2'd1, g, 0, lat, pulses, b0);
      total++; if (grid_out !== e) $display("FAIL win_grid: got %h expected %h", grid_out, e); else passed++;
      total++; if (win !== 1'b1) $display("FAIL win_flag: got %b expected 1", win); else passed++;
      total++; if (score_add !== 16'd2048) $display("FAIL win_score: got %0d expected 2048", score_add); else passed++;
      total++; if (score_add8 !== 8'd255) $display("FAIL sat_score8: got %0d expected 255", score_add8); else passed++;
      g = setrow(64'd0, 2, 4'd15, 4'd15, 4'd0, 4'd0);
      g = setrow(g, 3, 4'd11, 4'd0, 4'd0, 4'd0);
      run_move(2'd1, g, 0, lat, pulses, b0);
      total++; if (grid_out !== g) $display("FAIL f15_grid: got %h expected %h", grid_out, g); else passed++;
      total++; if (changed !== 1'b0) $display("FAIL f15_changed: got %b expected 0", changed); else passed++;
      total++; if (score_add !== 16'd0) $display("FAIL f15_score: got %0d expected 0", score_add); else passed++;
      total++; if (win !== 1'b0) $display("FAIL f15_win: got %b expected 0", win); else passed++;
      // Leave nonzero results behind for the mid-operation reset test.
      g = setrow(64'd0, 0, 4'd1, 4'd1, 4'd2, 4'd2);
      run_move(2'd1, g, 0, lat, pulses, b0);
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      @(negedge clk);
      dir = 2'd1; grid_in = setrow(64'd0, 0, 4'd3, 4'd3, 4'd0, 4'd0); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL mid_done: got %b expected 0", done); else passed++;
      total++; if (grid_out !== 64'd0) $display("FAIL mid_grid: got %h expected 0", grid_out); else passed++;
      total++; if (changed !== 1'b0) $display("FAIL mid_changed: got %b expected 0", changed); else passed++;
      total++; if (win !== 1'b0) $display("FAIL mid_win: got %b expected 0", win); else passed++;
      total++; if (score_add !== 16'd0) $display("FAIL mid_score: got %0d expected 0", score_add); else passed++;
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      total++; if (pulses != 0) $display("FAIL mid_no_done: got %0d expected 0", pulses); else passed++;
   endtask

`ifdef MOVE_SEQ_DEFEAT_EN
   task automatic test_defeat();
      int lat, pulses; logic b0; logic [63:0] g;
      g = 64'd0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            g[(r*4+c)*4 +: 4] = (((r + c) % 2) == 1) ? 4'd2 : 4'd1;
      run_move(2'd0, g, 0, lat, pulses, b0);
      total++; if (changed !== 1'b0) $display("FAIL defeat_changed: got %b expected 0", changed); else passed++;
      total++; if (no_moves !== 1'b1) $display("FAIL defeat_no_moves: got %b expected 1", no_moves); else passed++;
      total++; if (lat != 5) $display("FAIL defeat_latency: got %0d expected 5", lat); else passed++;
      g[3:0] = 4'd0;
      run_move(2'd0, g, 0, lat, pulses, b0);
      total++; if (changed !== 1'b0) $display("FAIL hole_changed: got %b expected 0", changed); else passed++;
      total++; if (no_moves !== 1'b0) $display("FAIL hole_no_moves: got %b expected 0", no_moves); else passed++;
      total++; if (pulses != 1) $display("FAIL hole_pulses: got %0d expected 1", pulses); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_left_merge();
      test_right_triple();
      test_up_down();
      test_noop_and_ignored_start();
      test_win_saturation();
      test_reset_mid();
`ifdef MOVE_SEQ_DEFEAT_EN
      test_defeat();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
